mem_arbiter: RTL

- Single-port RAM controller that shares the byte-wide main memory bus between instruction fetch (IF) and the load-store buffer (LSB).
- Serializes multi-byte accesses into byte beats and reassembles read data, with sign/zero extension of sub-word loads.
- Round-robin arbitration between the two requesters.
- Handles pipeline flush: in-flight fetches and loads are aborted; stores always complete.

---
 rtl/mem_arbiter.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: byte-wide RAM bus shared by instruction fetch and LSB.
// Round-robin grant, byte-beat serialisation, load extension, flush abort.
//
// Ports:
//   clk_in, rst_n_in (async active-low), rdy_in (pause), clear_in (flush)
//   if_req_in/if_addr_in -> if_done_out/if_data_out
//   lsb_req_in/lsb_wr_in/lsb_len_in/lsb_signed_in/lsb_addr_in/lsb_wdata_in
//     -> lsb_done_out/lsb_rdata_out
//   mem_din_in, mem_dout_out, mem_a_out, mem_wr_out, io_buffer_full_in
//
// Optional: define MEM_IO_WAIT_EN to stall IO store beats while
// io_buffer_full_in is high; otherwise that input is ignored.
module mem_arbiter #(
  parameter int          IF_BYTES = 4,
  parameter logic [31:0] IO_BASE  = 32'h0003_0000
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic        clear_in,
  input  logic        if_req_in,
  input  logic [31:0] if_addr_in,
  output logic        if_done_out,
  output logic [31:0] if_data_out,
  input  logic        lsb_req_in,
  input  logic        lsb_wr_in,
  input  logic [1:0]  lsb_len_in,
  input  logic        lsb_signed_in,
  input  logic [31:0] lsb_addr_in,
  input  logic [31:0] lsb_wdata_in,
  output logic        lsb_done_out,
  output logic [31:0] lsb_rdata_out,
  input  logic [7:0]  mem_din_in,
  output logic [7:0]  mem_dout_out,
  output logic [31:0] mem_a_out,
  output logic        mem_wr_out,
  input  logic        io_buffer_full_in
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_t;

  localparam logic [2:0] IF_N = 3'(IF_BYTES);

  state_t      state;
  logic [2:0]  cnt;
  logic [2:0]  n_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [1:0]  len_r;
  logic        sgn_r;
  logic        own_r;
  logic        st_r;
  logic        last_lsb;
  logic [31:0] rbuf;
  logic [31:0] a_r;
  logic [7:0]  dout_r;
  logic        wr_r;
  logic        if_done_r;
  logic        lsb_done_r;
  logic [31:0] if_data_r;
  logic [31:0] lsb_rdata_r;

  logic        grant_lsb;
  logic        any_req;
  logic [31:0] g_addr;
  logic [2:0]  g_n;
  logic [2:0]  lsb_n;
  logic        g_st;
  logic        last;
  logic [2:0]  nxt_cnt;
  logic [31:0] nxt_addr;
  logic [7:0]  nxt_byte;
  logic [31:0] merged;
  logic [31:0] ext;
  logic        stall;

  // Last grant is tracked as "was LSB"; on contention the other side wins.
  always_comb begin
    any_req   = if_req_in | lsb_req_in;
    grant_lsb = lsb_req_in & (~if_req_in | ~last_lsb);
    unique case (1'b1)
      lsb_len_in == 2'd0: lsb_n = 3'd1;
      lsb_len_in == 2'd1: lsb_n = 3'd2;
      default:            lsb_n = 3'd4;
    endcase
    g_addr = grant_lsb ? lsb_addr_in : if_addr_in;
    g_n    = grant_lsb ? lsb_n : IF_N;
    g_st   = grant_lsb & lsb_wr_in;
  end

  always_comb begin
    last     = (cnt == n_r - 3'd1);
    nxt_cnt  = cnt + 3'd1;
    nxt_addr = addr_r + 32'(nxt_cnt);
    nxt_byte = 8'(wdata_r >> {nxt_cnt[1:0], 3'b000});
    // rbuf starts at zero, so unfetched high bytes stay zero.
    merged   = rbuf | (32'(mem_din_in) << {cnt[1:0], 3'b000});
    unique case (1'b1)
      len_r == 2'd0:
        ext = sgn_r ? {{24{merged[7]}}, merged[7:0]}
                    : {24'b0, merged[7:0]};
      len_r == 2'd1:
        ext = sgn_r ? {{16{merged[15]}}, merged[15:0]}
                    : {16'b0, merged[15:0]};
      default:
        ext = merged;
    endcase
  end

`ifdef MEM_IO_WAIT_EN
  assign stall = (state == WRITE) && (a_r >= IO_BASE)
              && io_buffer_full_in;
`else
  logic unused_io;
  assign unused_io = io_buffer_full_in ^ (|IO_BASE);
  assign stall = 1'b0;
`endif

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state       <= IDLE;
      cnt         <= 3'd0;
      n_r         <= 3'd0;
      addr_r      <= 32'd0;
      wdata_r     <= 32'd0;
      len_r       <= 2'd0;
      sgn_r       <= 1'b0;
      own_r       <= 1'b0;
      st_r        <= 1'b0;
      last_lsb    <= 1'b0;
      rbuf        <= 32'd0;
      a_r         <= 32'd0;
      dout_r      <= 8'd0;
      wr_r        <= 1'b0;
      if_done_r   <= 1'b0;
      lsb_done_r  <= 1'b0;
      if_data_r   <= 32'd0;
      lsb_rdata_r <= 32'd0;
    end else if (rdy_in) begin
      if_done_r  <= 1'b0;
      lsb_done_r <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any_req && !clear_in) begin
            state    <= g_st ? WRITE : READ;
            cnt      <= 3'd0;
            n_r      <= g_n;
            addr_r   <= g_addr;
            wdata_r  <= lsb_wdata_in;
            len_r    <= lsb_len_in;
            sgn_r    <= lsb_signed_in;
            own_r    <= grant_lsb;
            st_r     <= g_st;
            last_lsb <= grant_lsb;
            rbuf     <= 32'd0;
            a_r      <= g_addr;
            wr_r     <= g_st;
            dout_r   <= g_st ? lsb_wdata_in[7:0] : 8'd0;
          end
        end
        READ: begin
          if (clear_in) begin
            state <= IDLE;
            a_r   <= 32'd0;
          end else if (last) begin
            state <= DONE;
            a_r   <= 32'd0;
            if (own_r) begin
              lsb_rdata_r <= ext;
              lsb_done_r  <= 1'b1;
            end else begin
              if_data_r <= merged;
              if_done_r <= 1'b1;
            end
          end else begin
            rbuf <= merged;
            cnt  <= nxt_cnt;
            a_r  <= nxt_addr;
          end
        end
        WRITE: begin
          if (!stall) begin
            if (last) begin
              state      <= DONE;
              a_r        <= 32'd0;
              wr_r       <= 1'b0;
              dout_r     <= 8'd0;
              lsb_done_r <= 1'b1;
            end else begin
              cnt    <= nxt_cnt;
              a_r    <= nxt_addr;
              dout_r <= nxt_byte;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Flush masks fetch/load completion; store completion survives.
  assign if_done_out   = if_done_r & ~clear_in;
  assign lsb_done_out  = lsb_done_r & ~(clear_in & ~st_r);
  assign if_data_out   = if_data_r;
  assign lsb_rdata_out = lsb_rdata_r;
  assign mem_a_out     = a_r;
  assign mem_dout_out  = dout_r;
  assign mem_wr_out    = wr_r & rdy_in & ~stall;

endmodule
